// File: rtl/mips150_io_pkg.sv
// Shared MIPS150 I/O definitions: region nibble, register offsets, status bit positions.
package mips150_io_pkg;

  localparam logic [3:0] IO_REGION = 4'h8;

  localparam logic [7:0] UART_STAT = 8'h00;
  localparam logic [7:0] UART_RX   = 8'h04;
  localparam logic [7:0] UART_TX   = 8'h08;
  localparam logic [7:0] CYC_CNT   = 8'h10;
  localparam logic [7:0] INS_CNT   = 8'h14;
  localparam logic [7:0] CNT_RST   = 8'h18;

  localparam int unsigned STAT_TX_IDLE     = 0;
  localparam int unsigned STAT_RX_NONEMPTY = 1;

endpackage

// File: rtl/io_rx_fifo.sv
// Synchronous FIFO for UART receive bytes; head is presented combinationally on dout.
module io_rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Full/empty come from the current count, so a push into a full FIFO is refused
  // even when a pop happens in the same cycle.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO controller between the MIPS150 data-memory port and the UART: decode, RX FIFO,
// TX holding register, cycle/instruction counters, 1-cycle-latency load data.
module uart_mmio_ctrl
  import mips150_io_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic        io_sel,
  output logic [31:0] dout,
  input  logic        instr_retire,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  logic [31:0]      dout_q, dout_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  logic       access, rd_en, wr_en, rx_pop;
  logic [7:0] off;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       unused_bits;

  assign unused_bits = ^{addr[27:8], din[31:8]};

  assign io_sel   = (addr[31:28] == IO_REGION);
  assign off      = addr[7:0];
  assign access   = io_sel & ~stall & (re | (|we));
  assign rd_en    = access & re;
  assign wr_en    = access & (|we);
  assign rx_pop   = rd_en & (off == UART_RX);
  assign rx_ready = ~fifo_full;
  assign dout     = dout_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

  io_rx_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid & rx_ready),
    .din   (rx_data),
    .full  (fifo_full),
    .pop   (rx_pop),
    .dout  (fifo_head),
    .empty (fifo_empty)
  );

  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      case (off)
        UART_STAT: begin
          dout_d                   = '0;
          dout_d[STAT_TX_IDLE]     = ~tx_valid_q;
          dout_d[STAT_RX_NONEMPTY] = ~fifo_empty;
        end
        UART_RX: dout_d = fifo_empty ? '0 : {24'b0, fifo_head};
        CYC_CNT: dout_d = 32'(cyc_q);
        INS_CNT: dout_d = 32'(ins_q);
        default: dout_d = '0;
      endcase
    end
  end

  // tx_idle is taken from the registered valid, so a store landing on the
  // handshake-completion cycle sees the port busy and is dropped.
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end else if (wr_en && off == UART_TX && !tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = din[7:0];
    end
  end

  always_comb begin
    cyc_d = cyc_q + 1'b1;
    ins_d = ins_q + CNT_W'(instr_retire & ~stall);
    if (wr_en && off == CNT_RST) begin
      cyc_d = '0;
      ins_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cyc_q      <= '0;
      ins_q      <= '0;
    end else begin
      dout_q     <= dout_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cyc_q      <= cyc_d;
      ins_q      <= ins_d;
    end
  end

endmodule
